// File: rtl/int2flt_a.sv
// int16 (sign + 15-bit magnitude) -> binary16 converter working through a local 256x8 memory.
// Operand is read from mem[0..1]; the half-precision result is written to mem[2..3].

module int2flt_a_mem #(
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [7:0]    wdata_i,
   input  logic [AW-1:0] raddr_a_i,
   input  logic [AW-1:0] raddr_b_i,
   output logic [7:0]    rdata_a_o,
   output logic [7:0]    rdata_b_o
);
   logic [7:0] mem_core [DEPTH];

   always_ff @(posedge clk)
      if (we_i) mem_core[waddr_i] <= wdata_i;

   assign rdata_a_o = mem_core[raddr_a_i];
   assign rdata_b_o = mem_core[raddr_b_i];
endmodule

module int2flt_a #(
   parameter int MEM_DEPTH  = 256,
   parameter int MAX_CYCLES = 40
) (
   input  logic clk,
   input  logic reset,
   input  logic req,
   output logic ack
);
   localparam int AW = $clog2(MEM_DEPTH);
   localparam logic [AW-1:0] ADDR_XHI = AW'(0);
   localparam logic [AW-1:0] ADDR_XLO = AW'(1);
   localparam logic [AW-1:0] ADDR_YHI = AW'(2);
   localparam logic [AW-1:0] ADDR_YLO = AW'(3);

   typedef enum logic [2:0] {IDLE, ARMED, LOAD, NORM, ROUND, ST_HI, ST_LO, DONE} state_t;

   state_t        state_q, state_d;
   logic          sgn_q, sgn_d;
   logic [14:0]   m_q, m_d;
   logic [3:0]    p_q, p_d;
   logic [4:0]    exp_q, exp_d;
   logic [9:0]    frac_q, frac_d;

   logic          we;
   logic [AW-1:0] waddr;
   logic [7:0]    wdata;
   logic [7:0]    x_hi, x_lo;
   logic          rnd;
   logic [11:0]   sig12;

   int2flt_a_mem #(.DEPTH(MEM_DEPTH)) data_mem1 (
      .clk       (clk),
      .we_i      (we),
      .waddr_i   (waddr),
      .wdata_i   (wdata),
      .raddr_a_i (ADDR_XHI),
      .raddr_b_i (ADDR_XLO),
      .rdata_a_o (x_hi),
      .rdata_b_o (x_lo)
   );

   // Once normalised, m_q[14] is the leading one, so the kept significand is always
   // m_q[14:4] and guard/sticky fall out of m_q[3:0] (all zero when p <= 10).
   assign rnd   = m_q[3] & (m_q[4] | (|m_q[2:0]));
   assign sig12 = {1'b0, m_q[14:4]} + 12'(rnd);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         sgn_q   <= 1'b0;
         m_q     <= '0;
         p_q     <= '0;
         exp_q   <= '0;
         frac_q  <= '0;
      end else begin
         state_q <= state_d;
         sgn_q   <= sgn_d;
         m_q     <= m_d;
         p_q     <= p_d;
         exp_q   <= exp_d;
         frac_q  <= frac_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sgn_d   = sgn_q;
      m_d     = m_q;
      p_d     = p_q;
      exp_d   = exp_q;
      frac_d  = frac_q;
      we      = 1'b0;
      waddr   = ADDR_YHI;
      wdata   = 8'h00;
      case (state_q)
         IDLE: ;
         ARMED: if (!req) state_d = LOAD;
         LOAD: begin
            sgn_d   = x_hi[7];
            m_d     = {x_hi[6:0], x_lo};
            p_d     = 4'd14;
            state_d = NORM;
         end
         NORM: begin
            if (m_q == '0) begin
               exp_d   = '0;
               frac_d  = '0;
               state_d = ST_HI;
            end else if (m_q[14]) begin
               state_d = ROUND;
            end else begin
               m_d = m_q << 1;
               p_d = p_q - 4'd1;
            end
         end
         ROUND: begin
            // A carry to 2048 leaves sig12[9:0] == 0, which is exactly the frac needed.
            exp_d   = 5'd15 + {1'b0, p_q} + 5'(sig12[11]);
            frac_d  = sig12[9:0];
            state_d = ST_HI;
         end
         ST_HI: begin
            we      = 1'b1;
            waddr   = ADDR_YHI;
            wdata   = {sgn_q, exp_q, frac_q[9:8]};
            state_d = ST_LO;
         end
         ST_LO: begin
            we      = 1'b1;
            waddr   = ADDR_YLO;
            wdata   = frac_q[7:0];
            state_d = DONE;
         end
         DONE: ;
         default: state_d = IDLE;
      endcase
      if (req) state_d = ARMED;
   end

   assign ack = (state_q == DONE);
endmodule

// File: tb/tb_int2flt_a.sv
// Self-checking bench for int2flt_a: directed table, random operands against an RNE
// model, and req/reset control scenarios.

module tb_int2flt_a;
   localparam int MAXC = 40;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic req = 1'b0;
   logic ack;

   int n_cmp = 0;
   int n_err = 0;

   int2flt_a #(.MEM_DEPTH(256), .MAX_CYCLES(MAXC)) dut (
      .clk(clk), .reset(reset), .req(req), .ack(ack)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] ref_h(input logic [15:0] x);
      int mag, p, q, rem, half, e, frac;
      mag = int'(x[14:0]);
      if (mag == 0) return {x[15], 15'd0};
      p = 0;
      while ((mag >> (p + 1)) != 0) p++;
      e = 15 + p;
      if (p <= 10) begin
         frac = (mag - (1 << p)) << (10 - p);
      end else begin
         q    = mag >> (p - 10);
         rem  = mag - (q << (p - 10));
         half = 1 << (p - 11);
         if (rem > half || (rem == half && (q % 2) == 1)) q++;
         if (q == 2048) begin
            e++;
            q = 1024;
         end
         frac = q - 1024;
      end
      return {x[15], 5'(e), 10'(frac)};
   endfunction

   task automatic load_x(input logic [15:0] x);
      dut.data_mem1.mem_core[0] = x[15:8];
      dut.data_mem1.mem_core[1] = x[7:0];
   endtask

   function automatic logic [15:0] result();
      return {dut.data_mem1.mem_core[2], dut.data_mem1.mem_core[3]};
   endfunction

   task automatic wait_ack(output int lat, output bit ok);
      lat = 0;
      ok  = 1'b0;
      for (int i = 0; i < MAXC; i++) begin
         @(negedge clk);
         lat++;
         if (ack) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_conv(input logic [15:0] x, output logic [15:0] y, output int lat, output bit ok);
      @(negedge clk);
      load_x(x);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      wait_ack(lat, ok);
      y = result();
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ack: got %b want 0", ack);
      end
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++;
         $display("FAIL idle_ack: got %b want 0", ack);
      end
   endtask

   task automatic test_directed();
      logic [15:0] xs [10] = '{16'h0000, 16'h8000, 16'h0001, 16'h0003, 16'h8001,
                               16'd32767, 16'd8191, 16'd2049, 16'd30767, 16'd1024};
      logic [15:0] ys [10] = '{16'h0000, 16'h8000, 16'h3C00, 16'h4200, 16'hBC00,
                               16'h7800, 16'h7000, 16'h6800, 16'h7783, 16'h6400};
      logic [15:0] y;
      int lat;
      bit ok;
      for (int i = 0; i < 10; i++) begin
         dut.data_mem1.mem_core[4] = 8'h5C;
         do_conv(xs[i], y, lat, ok);
         n_cmp++;
         if (!ok) begin
            n_err++;
            $display("FAIL dir_ack[%0d]: no ack within %0d cycles", i, MAXC);
         end
         n_cmp++;
         if (y !== ys[i]) begin
            n_err++;
            $display("FAIL dir_val x=%h: got %h want %h", xs[i], y, ys[i]);
         end
         n_cmp++;
         if ({dut.data_mem1.mem_core[0], dut.data_mem1.mem_core[1], dut.data_mem1.mem_core[4]}
             !== {xs[i], 8'h5C}) begin
            n_err++;
            $display("FAIL dir_untouched x=%h: got %h want %h", xs[i],
                     {dut.data_mem1.mem_core[0], dut.data_mem1.mem_core[1],
                      dut.data_mem1.mem_core[4]}, {xs[i], 8'h5C});
         end
      end
   endtask

   task automatic test_random();
      logic [15:0] x, y, w;
      int lat;
      bit ok;
      for (int i = 0; i < 20; i++) begin
         w = 16'($urandom);
         x = w >> $urandom_range(15, 0);
         do_conv(x, y, lat, ok);
         n_cmp++;
         if (!ok || y !== ref_h(x)) begin
            n_err++;
            $display("FAIL rand x=%h: got %h ack=%b want %h", x, y, ok, ref_h(x));
         end
      end
   endtask

   task automatic test_req_held();
      int lat;
      bit ok;
      logic [15:0] x = 16'd1000;
      @(negedge clk);
      load_x(x);
      dut.data_mem1.mem_core[2] = 8'hA5;
      dut.data_mem1.mem_core[3] = 8'h5A;
      req = 1'b1;
      repeat (15) @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0 || result() !== 16'hA55A) begin
         n_err++;
         $display("FAIL req_held: got ack=%b mem=%h want ack=0 mem=a55a", ack, result());
      end
      req = 1'b0;
      wait_ack(lat, ok);
      n_cmp++;
      if (!ok || result() !== ref_h(x)) begin
         n_err++;
         $display("FAIL req_held_result: got %h ack=%b want %h", result(), ok, ref_h(x));
      end
   endtask

   task automatic test_abort();
      int lat;
      bit ok;
      logic [15:0] x2 = 16'h8ABC;
      @(negedge clk);
      load_x(16'h0001);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (4) @(negedge clk);
      load_x(x2);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++;
         $display("FAIL abort_ack: got %b want 0", ack);
      end
      wait_ack(lat, ok);
      n_cmp++;
      if (!ok || result() !== ref_h(x2)) begin
         n_err++;
         $display("FAIL abort_result: got %h ack=%b want %h", result(), ok, ref_h(x2));
      end
   endtask

   task automatic test_reset_midrun();
      logic [15:0] y;
      int lat;
      bit ok;
      do_conv(16'd500, y, lat, ok);
      n_cmp++;
      if (ack !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_ack: got %b want 1", ack);
      end
      #2 reset = 1'b0;
      #1;
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++;
         $display("FAIL reset_drop_ack: got %b want 0", ack);
      end
      @(negedge clk);
      reset = 1'b1;
      // restart, then reset while still converting
      @(negedge clk);
      load_x(16'h0002);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (25) @(negedge clk);
      n_cmp++;
      if (ack !== 1'b0) begin
         n_err++;
         $display("FAIL reset_idle_ack: got %b want 0", ack);
      end
      do_conv(16'd12345, y, lat, ok);
      n_cmp++;
      if (!ok || y !== ref_h(16'd12345)) begin
         n_err++;
         $display("FAIL post_reset_conv: got %h ack=%b want %h", y, ok, ref_h(16'd12345));
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] xs [4] = '{16'h7FFF, 16'h0800, 16'h8FFF, 16'h0005};
      logic [15:0] y;
      int lat;
      bit ok;
      for (int i = 0; i < 4; i++) begin
         do_conv(xs[i], y, lat, ok);
         n_cmp++;
         if (!ok || y !== ref_h(xs[i])) begin
            n_err++;
            $display("FAIL b2b[%0d] x=%h: got %h ack=%b want %h", i, xs[i], y, ok, ref_h(xs[i]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_req_held();
      test_abort();
      test_reset_midrun();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
